// File: rtl/ipd_stream_arbiter.sv
// Packet-granular weighted round-robin arbiter sharing one inter-packet-delay stage
// between two AXI4-Stream sources; packets are never interleaved.
module ipd_stream_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_WEIGHT_WIDTH       = 8
) (
    input  logic                                axi_aclk,
    input  logic                                axi_resetn,
    input  logic                                sw_rst,
    input  logic                                arb_en,
    input  logic [C_WEIGHT_WIDTH-1:0]           weight0,
    input  logic [C_WEIGHT_WIDTH-1:0]           weight1,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis0_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis0_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis0_tuser,
    input  logic                                s_axis0_tvalid,
    input  logic                                s_axis0_tlast,
    output logic                                s_axis0_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis1_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis1_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis1_tuser,
    input  logic                                s_axis1_tvalid,
    input  logic                                s_axis1_tlast,
    output logic                                s_axis1_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,

    output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_cnt0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_cnt1
);

    localparam int WW = C_WEIGHT_WIDTH;
    localparam int CW = C_S_AXI_DATA_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PKT0 = 2'd1;
    localparam logic [1:0] PKT1 = 2'd2;

    logic [1:0]    state;
    logic          ptr;
    logic [WW-1:0] cred;

    logic [WW-1:0] w0_eff;
    logic [WW-1:0] w1_eff;
    logic [WW-1:0] w_grant;
    logic [WW-1:0] base;
    logic [WW-1:0] rem;
    logic          p_valid;
    logic          q_valid;
    logic          grant_src;
    logic          grant_fire;
    logic          pkt_done;
    logic          sel1;

    // Grant decision: the pointed-to source keeps its remaining credit; a fallback
    // grant to the other source starts a fresh turn at its full weight.
    always_comb begin
        w0_eff     = (weight0 == '0) ? WW'(1) : weight0;
        w1_eff     = (weight1 == '0) ? WW'(1) : weight1;
        p_valid    = ptr ? s_axis1_tvalid : s_axis0_tvalid;
        q_valid    = ptr ? s_axis0_tvalid : s_axis1_tvalid;
        grant_src  = p_valid ? ptr : ~ptr;
        grant_fire = (state == IDLE) && arb_en && (p_valid || q_valid);
        w_grant    = grant_src ? w1_eff : w0_eff;
        base       = (p_valid && (cred != '0)) ? cred : w_grant;
        rem        = base - WW'(1);
    end

    // In IDLE the payload mux follows ptr; tvalid is forced low so it is unobservable.
    always_comb begin
        sel1           = (state == PKT1) || ((state != PKT0) && ptr);
        m_axis_tdata   = sel1 ? s_axis1_tdata  : s_axis0_tdata;
        m_axis_tstrb   = sel1 ? s_axis1_tstrb  : s_axis0_tstrb;
        m_axis_tuser   = sel1 ? s_axis1_tuser  : s_axis0_tuser;
        m_axis_tlast   = sel1 ? s_axis1_tlast  : s_axis0_tlast;
        m_axis_tvalid  = ((state == PKT0) && s_axis0_tvalid) ||
                         ((state == PKT1) && s_axis1_tvalid);
        s_axis0_tready = (state == PKT0) && m_axis_tready;
        s_axis1_tready = (state == PKT1) && m_axis_tready;
        pkt_done       = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            cred     <= '0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (sw_rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            cred     <= '0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        state <= grant_src ? PKT1 : PKT0;
                        if (rem == '0) begin
                            ptr  <= ~grant_src;
                            cred <= '0;
                        end else begin
                            ptr  <= grant_src;
                            cred <= rem;
                        end
                    end
                end
                PKT0: begin
                    if (pkt_done) begin
                        pkt_cnt0 <= pkt_cnt0 + CW'(1);
                        state    <= IDLE;
                    end
                end
                PKT1: begin
                    if (pkt_done) begin
                        pkt_cnt1 <= pkt_cnt1 + CW'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipd_stream_arbiter.sv
// Scoreboard bench for ipd_stream_arbiter: a packet-level WRR model predicts the output
// beat order; a monitor pops and compares on every output handshake.
module tb_ipd_stream_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int CW = 32;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sw_rst = 1'b0;
    logic          arb_en = 1'b0;
    logic [WW-1:0] weight0 = '0;
    logic [WW-1:0] weight1 = '0;
    logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic [SW-1:0] s0_tstrb = '0, s1_tstrb = '0;
    logic [UW-1:0] s0_tuser = '0, s1_tuser = '0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          s0_tready, s1_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic          m_tlast, m_tvalid;
    logic          m_tready = 1'b1;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    ipd_stream_arbiter dut (
        .axi_aclk(clk), .axi_resetn(rst_n), .sw_rst(sw_rst), .arb_en(arb_en),
        .weight0(weight0), .weight1(weight1),
        .s_axis0_tdata(s0_tdata), .s_axis0_tstrb(s0_tstrb), .s_axis0_tuser(s0_tuser),
        .s_axis0_tvalid(s0_tvalid), .s_axis0_tlast(s0_tlast), .s_axis0_tready(s0_tready),
        .s_axis1_tdata(s1_tdata), .s_axis1_tstrb(s1_tstrb), .s_axis1_tuser(s1_tuser),
        .s_axis1_tvalid(s1_tvalid), .s_axis1_tlast(s1_tlast), .s_axis1_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t   src0_q[$], src1_q[$], exp_q[$];
    int      ord_q[$];
    longint  hs_cyc[$];
    longint  cyc = 0;
    int      checks = 0, errors = 0, out_beats = 0, s0_rdy_seen = 0;
    int      stall_en = 0, mrdy_mode = 0, st0 = 0, st1 = 0, seq = 0;
    int      m_ptr = 0, m_cred = 0;
    logic [CW-1:0] tot0 = '0, tot1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t make_beat(input int src, input int pk, input int idx, input bit last);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
        for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
        b.strb = $urandom;
        b.data[7:0]   = 8'(src);
        b.data[15:8]  = 8'(pk);
        b.data[23:16] = 8'(idx);
        b.last = last;
        return b;
    endfunction

    function automatic int weff(input logic [WW-1:0] w);
        return (w == 0) ? 1 : int'(w);
    endfunction

    // Build packets for both sources, then replay the WRR rules packet by packet
    // (all packets are queued before arb_en rises) to get the expected output stream.
    task automatic load(input int n0, input int n1, input int lo, input int hi);
        beat_t t0[$], t1[$];
        beat_t nb;
        int r0, r1, g, bs, rm;
        for (int i = 0; i < n0 + n1; i++) begin
            int len = $urandom_range(lo, hi);
            for (int b = 0; b < len; b++) begin
                nb = make_beat((i < n0) ? 0 : 1, seq, b, b == len - 1);
                if (i < n0) begin src0_q.push_back(nb); t0.push_back(nb); end
                else        begin src1_q.push_back(nb); t1.push_back(nb); end
            end
            seq++;
        end
        r0 = n0; r1 = n1;
        while (r0 + r1 > 0) begin
            if ((m_ptr == 0 && r0 > 0) || (m_ptr == 1 && r1 > 0)) begin
                g  = m_ptr;
                bs = (m_cred == 0) ? weff(g ? weight1 : weight0) : m_cred;
            end else begin
                g     = 1 - m_ptr;
                m_ptr = g;
                bs    = weff(g ? weight1 : weight0);
            end
            rm = bs - 1;
            if (rm == 0) begin m_ptr = 1 - g; m_cred = 0; end
            else m_cred = rm;
            if (g == 0) begin
                r0--; tot0 = tot0 + 1;
                do begin nb = t0.pop_front(); exp_q.push_back(nb); end while (!nb.last);
            end else begin
                r1--; tot1 = tot1 + 1;
                do begin nb = t1.pop_front(); exp_q.push_back(nb); end while (!nb.last);
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (out_beats < n && k < budget) begin @(posedge clk); k++; end
        if (out_beats < n) begin
            checks++; errors++;
            $display("FAIL wait_beats: got %0d beats expected %0d", out_beats, n);
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin @(posedge clk); k++; end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d beats pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pkt_cnt0", pkt_cnt0, tot0);
        chk("pkt_cnt1", pkt_cnt1, tot1);
    endtask

    task automatic start();
        repeat (2) @(posedge clk);
        #2 arb_en = 1'b1;
    endtask

    // Monitor: every output handshake is checked against the scoreboard head.
    initial begin
        beat_t e;
        int    src;
        forever begin
            @(negedge clk);
            if (s0_tready) s0_rdy_seen++;
            if (rst_n && m_tvalid && m_tready) begin
                out_beats++;
                hs_cyc.push_back(cyc);
                src = int'(m_tdata[7:0]);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_tdata[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_side", {m_tuser, m_tstrb, m_tlast}, {e.user, e.strb, e.last});
                end
                chk("ready_route", {s0_tready, s1_tready}, (src == 0) ? 2'b10 : 2'b01);
                if (m_tlast) ord_q.push_back(src);
            end
        end
    end

    // Source drivers: hold each beat until accepted, optional gaps inside a packet.
    initial begin
        bit f0, f1;
        forever begin
            @(negedge clk);
            f0 = s0_tvalid && s0_tready;
            f1 = s1_tvalid && s1_tready;
            @(posedge clk);
            #1;
            if (f0 && src0_q.size() > 0) begin
                st0 = (stall_en != 0 && !src0_q[0].last) ? int'($urandom_range(0, 2)) : 0;
                src0_q.delete(0);
            end else if (st0 > 0) st0--;
            if (f1 && src1_q.size() > 0) begin
                st1 = (stall_en != 0 && !src1_q[0].last) ? int'($urandom_range(0, 2)) : 0;
                src1_q.delete(0);
            end else if (st1 > 0) st1--;
            s0_tvalid = (src0_q.size() > 0) && (st0 == 0);
            if (src0_q.size() > 0) begin
                s0_tdata = src0_q[0].data; s0_tuser = src0_q[0].user;
                s0_tstrb = src0_q[0].strb; s0_tlast = src0_q[0].last;
            end
            s1_tvalid = (src1_q.size() > 0) && (st1 == 0);
            if (src1_q.size() > 0) begin
                s1_tdata = src1_q[0].data; s1_tuser = src1_q[0].user;
                s1_tstrb = src1_q[0].strb; s1_tlast = src1_q[0].last;
            end
            if (mrdy_mode == 0) m_tready = 1'b1;
            else if (mrdy_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ov;
        int base, hi_cnt, n1s;

        repeat (3) @(negedge clk);
        chk("rst_outputs", {m_tvalid, s0_tready, s1_tready}, 3'b000);
        chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // 3:1 weighting, saturated 2-beat packets
        weight0 = 8'd3; weight1 = 8'd1; ord_q.delete();
        load(6, 2, 2, 2); start(); drain(400);
        ov = '0;
        for (int i = 0; i < ord_q.size() && i < 8; i++) ov[7-i] = ord_q[i][0];
        chk("wrr31_order", ov, 8'b0001_0001);
        chk("wrr31_cnt", {pkt_cnt0, pkt_cnt1}, {32'd6, 32'd2});

        // zero weights alternate; 1-beat packets take two cycles each
        arb_en = 1'b0; weight0 = '0; weight1 = '0; ord_q.delete(); hs_cyc.delete();
        load(4, 4, 1, 1); start(); drain(400);
        ov = '0;
        for (int i = 0; i < ord_q.size() && i < 8; i++) ov[7-i] = ord_q[i][0];
        chk("alt_order", ov, 8'b0101_0101);
        chk("alt_span", (hs_cyc.size() == 8) ? hs_cyc[7] - hs_cyc[0] : -1, 14);

        // only source 1 active, stalls and random backpressure
        arb_en = 1'b0; weight0 = 8'd2; weight1 = 8'd4; stall_en = 1; mrdy_mode = 1;
        ord_q.delete(); s0_rdy_seen = 0;
        load(0, 5, 1, 3); start(); drain(800);
        n1s = 0;
        foreach (ord_q[i]) if (ord_q[i] == 1) n1s++;
        chk("only1_pkts", n1s, 5);
        chk("only1_s0_ready", s0_rdy_seen, 0);

        // idle soft reset, then backpressure hold in the middle of a packet
        arb_en = 1'b0; stall_en = 0; mrdy_mode = 2; m_tready = 1'b1;
        @(posedge clk); #2 sw_rst = 1'b1;
        @(posedge clk); #2 sw_rst = 1'b0;
        m_ptr = 0; m_cred = 0; tot0 = '0; tot1 = '0;
        @(negedge clk);
        chk("swrst_idle_cnt", {pkt_cnt0, pkt_cnt1}, 64'd0);
        weight0 = 8'd1; weight1 = 8'd1;
        load(1, 1, 4, 4);
        base = out_beats; start();
        wait_beats(base + 1, 50);
        #2 m_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {m_tvalid, s0_tready, s1_tready, m_tdata},
                {1'b1, 1'b0, 1'b0, exp_q[0].data});
        end
        @(posedge clk); #2 m_tready = 1'b1;
        wait_beats(base + 4, 50);
        @(negedge clk);
        chk("bp_idle_after_last", m_tvalid, 1'b0);
        mrdy_mode = 0; drain(200);

        // arb_en dropped mid-packet: packet completes, then quiet until re-enabled
        arb_en = 1'b0; ord_q.delete();
        load(3, 3, 4, 4);
        base = out_beats; start();
        wait_beats(base + 1, 50);
        #2 arb_en = 1'b0;
        wait_beats(base + 4, 50);
        hi_cnt = 0;
        repeat (10) begin @(negedge clk); if (m_tvalid) hi_cnt++; end
        chk("en_off_quiet", hi_cnt, 0);
        chk("en_off_beats", out_beats - base, 4);
        @(posedge clk); #2 arb_en = 1'b1;
        drain(400);
        ov = '0;
        for (int i = 0; i < ord_q.size() && i < 6; i++) ov[5-i] = ord_q[i][0];
        chk("en_resume_order", ov, 8'b0001_0101);

        // soft reset mid-packet truncates the packet and clears the counters
        arb_en = 1'b0;
        load(1, 1, 4, 4);
        base = out_beats; start();
        wait_beats(base + 1, 50);
        #2 sw_rst = 1'b1;
        @(posedge clk); #2 sw_rst = 1'b0; arb_en = 1'b0;
        @(negedge clk);
        chk("swrst_pkt_outputs", {m_tvalid, s0_tready, s1_tready}, 3'b000);
        chk("swrst_pkt_cnt", {pkt_cnt0, pkt_cnt1}, 64'd0);
        #1;
        src0_q.delete(); src1_q.delete(); exp_q.delete(); st0 = 0; st1 = 0;
        m_ptr = 0; m_cred = 0; tot0 = '0; tot1 = '0;
        repeat (5) @(posedge clk);
        chk("swrst_truncated", out_beats - base, 2);

        // counter wrap from all-ones
        @(negedge clk);
        force dut.pkt_cnt0 = 32'hFFFF_FFFF;
        @(posedge clk); #2 release dut.pkt_cnt0;
        tot0 = 32'hFFFF_FFFF;
        load(1, 0, 2, 2); start(); drain(200);
        chk("wrap_cnt0", pkt_cnt0, 32'd0);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            arb_en = 1'b0; stall_en = 1; mrdy_mode = 1;
            weight0 = 8'($urandom_range(0, 3));
            weight1 = 8'($urandom_range(0, 3));
            load($urandom_range(0, 5), $urandom_range(0, 5), 1, 4);
            start(); drain(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
